// File: rtl/msg_pkg.sv
//------------------------------------------------------------------------------
// Module   : msg_pkg
// Brief    : Shared types and constants for the message memory read path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package msg_pkg;

    localparam int MSG_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } streamer_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } stream_beat_t;

endpackage : msg_pkg

`default_nettype wire

// File: rtl/stream_fifo.sv
//------------------------------------------------------------------------------
// Module   : stream_fifo
// Brief    : First-word-fall-through FIFO of stream beats, power-of-two depth.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_fifo
    import msg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  stream_beat_t             push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output stream_beat_t             out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    stream_beat_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push & ~w_full;
    assign w_do_pop  = pop & ~w_empty;

    // Storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rptr];
    assign count     = r_count;

endmodule : stream_fifo

`default_nettype wire

// File: rtl/message_streamer.sv
//------------------------------------------------------------------------------
// Module   : message_streamer
// Brief    : Fetches a contiguous byte run from the message memory and emits it
//            as a valid/ready byte stream with a last-byte marker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module message_streamer
    import msg_pkg::*;
#(
    parameter int ADDR_W     = MSG_ADDR_W,
    parameter int LEN_W      = ADDR_W + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              m_valid,
    output logic [7:0]        m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    streamer_state_e     r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_issue_cnt;
    logic [LEN_W-1:0]    r_emit_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pipe_valid;
    logic                r_pipe_last;

    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_valid;
    logic                w_issue;
    logic                w_pop;
    stream_beat_t        w_push_beat;
    stream_beat_t        w_head;

    // Credit: buffered beats plus the one read in flight must leave a free slot.
    assign w_issue = (r_state == FETCH) &&
                     ((32'(w_fifo_count) + 32'(r_pipe_valid)) < 32'(FIFO_DEPTH));
    assign w_pop   = w_fifo_valid & m_ready;

    assign w_push_beat = '{data: rd_data, last: r_pipe_last};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_issue_cnt  <= '0;
            r_emit_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_last  <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_pipe_valid <= w_issue;
            if (w_issue) begin
                r_pipe_last <= (r_issue_cnt == LEN_W'(1));
            end
            if (w_pop) begin
                r_emit_cnt <= r_emit_cnt - LEN_W'(1);
            end

            case (r_state)
                IDLE: begin
                    // The done pulse cycle still belongs to the finished command.
                    if (start && !r_done) begin
                        r_busy      <= 1'b1;
                        r_addr      <= start_addr;
                        r_issue_cnt <= length;
                        r_emit_cnt  <= length;
                        r_state     <= (length == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
                        if (r_issue_cnt == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && (r_emit_cnt == LEN_W'(1))) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pipe_valid),
        .push_data (w_push_beat),
        .pop       (w_pop),
        .out_valid (w_fifo_valid),
        .out_data  (w_head),
        .count     (w_fifo_count)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_addr = r_addr;
    assign m_valid = w_fifo_valid;
    assign m_data  = w_head.data;
    assign m_last  = w_fifo_valid & w_head.last;

endmodule : message_streamer

`default_nettype wire

// File: tb/tb_message_streamer.sv
//------------------------------------------------------------------------------
// Module   : tb_message_streamer
// Brief    : Directed self-checking bench for message_streamer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_message_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic [8:0] length = '0;
    logic       busy;
    logic       done;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [256];

    logic [7:0] got_data [$];
    logic       got_last [$];
    logic [7:0] addr_seq [$];
    int first_valid, first_hs, last_hs, done_at, done_cnt, max_out, stable_err;
    logic busy_at1;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    message_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 3 && c <= 12) return 1'b0;
        return (c % 3) != 0;
    endfunction

    // Iteration c samples the state left by edge k+c-1, where k is the start edge.
    task automatic run_xfer(input logic [7:0] a, input logic [8:0] len, input int mode, input int budget);
        int c;
        int o;
        logic [7:0] prev_addr, pd;
        logic pv, pr, pl;
        got_data.delete(); got_last.delete(); addr_seq.delete();
        first_valid = -1; first_hs = -1; last_hs = -1; done_at = -1;
        done_cnt = 0; max_out = 0; stable_err = 0; busy_at1 = 1'b0;
        prev_addr = rd_addr; pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        start_addr = a; length = len; start = 1'b1; m_ready = ready_for(mode, 0);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c <= budget && !(done_at >= 0 && c >= done_at + 2)) begin
            m_ready = ready_for(mode, c);
            if (mode == 1 && c == 5) begin
                start_addr = 8'h50; length = 9'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 1) busy_at1 = busy;
            if (rd_addr !== prev_addr) begin
                addr_seq.push_back(rd_addr);
                prev_addr = rd_addr;
            end
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stable_err++;
            if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            o = addr_seq.size() - got_data.size();
            if (o > max_out) max_out = o;
            if (m_valid === 1'b1 && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, m_valid, m_last, m_data, rd_addr} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_held: got %05h expected 00000", {busy, done, m_valid, m_last, m_data, rd_addr});
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, m_valid, m_last, m_data, rd_addr} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_released: got %05h expected 00000", {busy, done, m_valid, m_last, m_data, rd_addr});
        end
    endtask

    task automatic test_basic();
        logic [3:0] lasts;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'hA0 + 8'(i);
        run_xfer(8'h10, 9'd4, 0, 40);
        tests_run++;
        if (got_data.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d expected 4", got_data.size());
        end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== 8'hA0 + 8'(i)) begin
                tests_failed++;
                $display("FAIL basic_data[%0d]: got %02h expected %02h", i, got_data[i], 8'hA0 + 8'(i));
            end
        end
        lasts = '0;
        for (int i = 0; i < 4 && i < got_last.size(); i++) lasts[i] = got_last[i];
        tests_run++;
        if (lasts !== 4'b1000) begin
            tests_failed++;
            $display("FAIL basic_last: got %b expected 1000", lasts);
        end
        tests_run++;
        if (first_valid != 3) begin
            tests_failed++;
            $display("FAIL basic_first_valid: got %0d expected 3", first_valid);
        end
        tests_run++;
        if (last_hs - first_hs != 3) begin
            tests_failed++;
            $display("FAIL basic_no_bubbles: got span %0d expected 3", last_hs - first_hs);
        end
        tests_run++;
        if (done_cnt != 1 || done_at != last_hs + 2) begin
            tests_failed++;
            $display("FAIL basic_done: got count %0d at %0d expected 1 at %0d", done_cnt, done_at, last_hs + 2);
        end
        tests_run++;
        if (busy_at1 !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy: got %b/%b expected 1/0", busy_at1, busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4];
        logic [7:0] exp_d [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_d = '{8'h5E, 8'h5F, 8'h60, 8'h61};
        for (int i = 0; i < 4; i++) mem[exp_a[i]] = exp_d[i];
        run_xfer(8'hFE, 9'd4, 0, 40);
        tests_run++;
        if (addr_seq.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_addr_count: got %0d expected 4", addr_seq.size());
        end
        for (int i = 0; i < 4 && i < addr_seq.size(); i++) begin
            tests_run++;
            if (addr_seq[i] !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL wrap_addr[%0d]: got %02h expected %02h", i, addr_seq[i], exp_a[i]);
            end
        end
        tests_run++;
        if (got_data.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d expected 4", got_data.size());
        end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL wrap_data[%0d]: got %02h expected %02h", i, got_data[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        run_xfer(8'h33, 9'd0, 0, 20);
        tests_run++;
        if (done_cnt != 1 || done_at != 2) begin
            tests_failed++;
            $display("FAIL zero_done: got count %0d at %0d expected 1 at 2", done_cnt, done_at);
        end
        tests_run++;
        if (first_valid != -1 || got_data.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_no_valid: got first_valid %0d beats %0d expected -1 and 0", first_valid, got_data.size());
        end
    endtask

    task automatic test_stall();
        logic [5:0] lasts;
        for (int i = 0; i < 6; i++) mem[8'h20 + i] = 8'hC0 + 8'(i);
        run_xfer(8'h20, 9'd6, 1, 100);
        tests_run++;
        if (got_data.size() != 6) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d expected 6", got_data.size());
        end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== 8'hC0 + 8'(i)) begin
                tests_failed++;
                $display("FAIL stall_data[%0d]: got %02h expected %02h", i, got_data[i], 8'hC0 + 8'(i));
            end
        end
        lasts = '0;
        for (int i = 0; i < 6 && i < got_last.size(); i++) lasts[i] = got_last[i];
        tests_run++;
        if (lasts !== 6'b100000) begin
            tests_failed++;
            $display("FAIL stall_last: got %b expected 100000", lasts);
        end
        tests_run++;
        if (stable_err != 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", stable_err);
        end
        tests_run++;
        if (max_out > 5) begin
            tests_failed++;
            $display("FAIL stall_outstanding: got %0d expected at most 5", max_out);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL stall_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_full_memory();
        int errs;
        int nlast;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        run_xfer(8'h00, 9'd256, 0, 400);
        tests_run++;
        if (got_data.size() != 256) begin
            tests_failed++;
            $display("FAIL full_count: got %0d expected 256", got_data.size());
        end
        errs = 0;
        nlast = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== 8'(i * 7 + 3)) errs++;
            if (got_last[i] === 1'b1) nlast++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL full_data: got %0d wrong bytes expected 0", errs);
        end
        tests_run++;
        if (nlast != 1 || got_last.size() != 256 || got_last[255] !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_last: got %0d markers expected 1 on byte 256", nlast);
        end
        tests_run++;
        if (last_hs - first_hs != 255) begin
            tests_failed++;
            $display("FAIL full_no_bubbles: got span %0d expected 255", last_hs - first_hs);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL full_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        int c;
        int done_seen;
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 8; i++) mem[8'h30 + i] = 8'h70 + 8'(i);
        start_addr = 8'h30; length = 9'd8; start = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        c = 0;
        while (hs < 3 && c < 20) begin
            if (m_valid === 1'b1) hs++;
            @(negedge clk);
            c++;
        end
        tests_run++;
        if (hs != 3) begin
            tests_failed++;
            $display("FAIL rstmid_beats: got %0d expected 3", hs);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, m_valid, m_last, m_data, rd_addr} !== 20'h0) begin
            tests_failed++;
            $display("FAIL rstmid_cleared: got %05h expected 00000", {busy, done, m_valid, m_last, m_data, rd_addr});
        end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || m_valid === 1'b1) done_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || m_valid === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen);
        end
        for (int i = 0; i < 3; i++) mem[8'h40 + i] = exp_d[i];
        run_xfer(8'h40, 9'd3, 0, 40);
        tests_run++;
        if (got_data.size() != 3 || done_cnt != 1 || first_valid != 3) begin
            tests_failed++;
            $display("FAIL rstmid_next: got %0d beats done %0d first %0d expected 3/1/3", got_data.size(), done_cnt, first_valid);
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL rstmid_data[%0d]: got %02h expected %02h", i, got_data[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_stall();
        test_full_memory();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_message_streamer

`default_nettype wire
